// File: rtl/line_capture_ctrl.sv
// line_capture_ctrl
//   Frame-lock tracker and decimating line capture for a sampled video stream.
//   A frame FSM (SEARCH/VERIFY/LOCKED) watches the line count between V-syncs.
//   Once locked, active lines are decimated 3:2 into a ping-pong line buffer.
//   Completed lines are handed to a consumer with a ready/ack handshake.
//
// Ports
//   clk, rst          : system clock; asynchronous active-high reset
//   sample_valid      : qualifies h_sync_pulse, v_sync_pulse, active_video and adc_data
//   h_sync_pulse      : line start
//   v_sync_pulse      : frame start (may coincide with h_sync_pulse)
//   active_video      : sample lies inside the active window
//   adc_data[11:0]    : raw video sample
//   line_ack          : consumer has taken the ready line (honoured on any clk)
//   wr_en/wr_addr/wr_data/wr_bank : line-buffer write port, registered
//   line_ready/line_bank/line_num : completed-line descriptor
//   locked            : frame lock held
//   overrun           : one-clk pulse when a completed line is dropped
module line_capture_ctrl #(
  parameter int unsigned FIRST_ACTIVE_LINE = 21,
  parameter int unsigned ACTIVE_LINES      = 240,
  parameter int unsigned LINES_MIN         = 250,
  parameter int unsigned LINES_MAX         = 320,
  parameter int unsigned LOCK_FRAMES       = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_valid,
  input  logic        h_sync_pulse,
  input  logic        v_sync_pulse,
  input  logic        active_video,
  input  logic [11:0] adc_data,
  input  logic        line_ack,
  output logic        wr_en,
  output logic [10:0] wr_addr,
  output logic [11:0] wr_data,
  output logic        wr_bank,
  output logic        line_ready,
  output logic        line_bank,
  output logic [8:0]  line_num,
  output logic        locked,
  output logic        overrun
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [9:0]  CAP_FIRST   = 10'(FIRST_ACTIVE_LINE);
  localparam logic [9:0]  CAP_END     = 10'(FIRST_ACTIVE_LINE + ACTIVE_LINES);
  localparam logic [8:0]  FIRST_LINE  = 9'(FIRST_ACTIVE_LINE);
  localparam logic [8:0]  MIN_LINES   = 9'(LINES_MIN);
  localparam logic [8:0]  MAX_LINES   = 9'(LINES_MAX);
  localparam logic [2:0]  LOCK_TARGET = 3'(LOCK_FRAMES);
  localparam logic [10:0] LINE_PIXELS = 11'd1280;

  state_t      state;
  logic [1:0]  good_frames;
  logic [8:0]  line_count;
  logic [1:0]  phase;
  logic [10:0] pix;

  logic        capturing;
  logic        count_ok;
  logic [8:0]  count_inc;
  logic [2:0]  good_next;
  logic        line_done;
  logic        do_write;

  always_comb begin
    capturing = locked
                && ({1'b0, line_count} >= CAP_FIRST)
                && ({1'b0, line_count} <  CAP_END);
    count_ok  = (line_count >= MIN_LINES) && (line_count <= MAX_LINES);
    count_inc = (line_count == '1) ? line_count : line_count + 9'd1;
    good_next = {1'b0, good_frames} + 3'd1;
    // A line is closed only if it was capturing and actually wrote something;
    // pix doubles as the "wrote at least one pixel" flag.
    line_done = sample_valid && h_sync_pulse && capturing && (pix != '0);
    // Samples arriving with h_sync_pulse are treated as blanking.
    do_write  = sample_valid && !h_sync_pulse && active_video && capturing
                && (phase != 2'd2) && (pix < LINE_PIXELS);
  end

  // Frame-lock FSM and line counter. On a coincident V/H sync the frame is
  // judged on the pre-clear count, then the count restarts at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= SEARCH;
      good_frames <= '0;
      line_count  <= '0;
      locked      <= 1'b0;
    end else if (sample_valid) begin
      if (v_sync_pulse) begin
        line_count <= '0;
        case (state)
          SEARCH: begin
            state       <= VERIFY;
            good_frames <= '0;
            locked      <= 1'b0;
          end
          VERIFY: begin
            if (count_ok) begin
              good_frames <= good_next[1:0];
              if (good_next >= LOCK_TARGET) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              good_frames <= '0;
            end
          end
          LOCKED: begin
            if (!count_ok) begin
              state       <= SEARCH;
              good_frames <= '0;
              locked      <= 1'b0;
            end
          end
          default: begin
            state       <= SEARCH;
            good_frames <= '0;
            locked      <= 1'b0;
          end
        endcase
      end else if (h_sync_pulse) begin
        line_count <= count_inc;
        // Over-long frame: drop lock as soon as the count passes the limit.
        if ((state == LOCKED) && (count_inc > MAX_LINES)) begin
          state       <= SEARCH;
          good_frames <= '0;
          locked      <= 1'b0;
        end
      end
    end
  end

  // Capture datapath and line handoff.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase      <= '0;
      pix        <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      wr_bank    <= 1'b0;
      line_ready <= 1'b0;
      line_bank  <= 1'b0;
      line_num   <= '0;
      overrun    <= 1'b0;
    end else begin
      wr_en   <= 1'b0;
      overrun <= 1'b0;

      if (line_ack && line_ready)
        line_ready <= 1'b0;

      if (sample_valid) begin
        if (h_sync_pulse) begin
          phase <= '0;
          pix   <= '0;
        end else if (active_video) begin
          phase <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
          if (do_write) begin
            wr_en   <= 1'b1;
            wr_addr <= pix;
            wr_data <= adc_data;
            pix     <= pix + 11'd1;
          end
        end

        // A simultaneous ack frees the slot, so the new line replaces the old
        // one and line_ready stays high (the assignment below wins).
        if (line_done) begin
          if (line_ready && !line_ack) begin
            overrun <= 1'b1;
          end else begin
            line_ready <= 1'b1;
            line_bank  <= wr_bank;
            line_num   <= line_count - FIRST_LINE;
            wr_bank    <= ~wr_bank;
          end
        end
      end
    end
  end

endmodule
